// File: rtl/hazard_pkg.sv
// Shared types and latency classes for the ID-stage hazard scoreboard.
// Default machine shape; the top module may be re-parametrised independently.
package hazard_pkg;
  localparam int NUM_REGS = 32;
  localparam int MAX_LAT  = 7;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int LAT_W    = $clog2(MAX_LAT + 1);

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0] lat_t;

  localparam lat_t LAT_ALU  = lat_t'(0);
  localparam lat_t LAT_LOAD = lat_t'(1);
  localparam lat_t LAT_MUL  = lat_t'(2);
  localparam lat_t LAT_DIV  = lat_t'(MAX_LAT);
endpackage

// File: rtl/hazard_sb_entry.sv
// One register's countdown: cycles remaining until its pending result
// can be forwarded to ID. Kill beats set, set beats decrement.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W_P = LAT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set,
  input  logic [LAT_W_P-1:0] set_val,
  input  logic               kill,
  output logic               busy,
  output logic [LAT_W_P-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (kill) begin
      value <= '0;
    end else if (set) begin
      value <= set_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign busy = (value != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency scoreboard beside ID: RAW/WAW stall decisions from per-register
// countdowns, issue tracking, kill support and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = hazard_pkg::NUM_REGS,
  parameter int MAX_LAT  = hazard_pkg::MAX_LAT,
  parameter int PERF_W   = 32,
  localparam int IDX_W_L = $clog2(NUM_REGS),
  localparam int LAT_W_L = $clog2(MAX_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [IDX_W_L-1:0] id_rs1,
  input  logic [IDX_W_L-1:0] id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic               id_is_store,
  input  logic [IDX_W_L-1:0] id_rd,
  input  logic               id_reg_wr,
  input  logic [LAT_W_L-1:0] id_lat,
  input  logic               flush,
  input  logic               kill_all,
  output logic               stall,
  output logic               flush_id_ex,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [PERF_W-1:0]  stall_cycles
);

  localparam logic [LAT_W_L-1:0] MAX_LAT_V = LAT_W_L'(MAX_LAT);

  logic [LAT_W_L-1:0] cnt [NUM_REGS];
  logic [LAT_W_L-1:0] lat_e;
  logic [LAT_W_L-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic               raw1, raw2, waw, issue;

  assign cnt[0]       = '0;
  assign busy_mask[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      hazard_sb_entry #(.LAT_W_P(LAT_W_L)) u_entry (
        .clk     (clk),
        .rst     (rst),
        .set     (issue && id_reg_wr && (id_rd == IDX_W_L'(gi))),
        .set_val (lat_e),
        .kill    (kill_all),
        .busy    (busy_mask[gi]),
        .value   (cnt[gi])
      );
    end
  endgenerate

  assign lat_e   = (id_lat > MAX_LAT_V) ? MAX_LAT_V : id_lat;
  assign cnt_rs1 = cnt[id_rs1];
  assign cnt_rs2 = cnt[id_rs2];
  assign cnt_rd  = cnt[id_rd];

  // Store data is consumed in MEM, so a result arriving one cycle late is fine.
  assign raw1 = id_rs1_used && (id_rs1 != '0) && (cnt_rs1 != '0);
  assign raw2 = id_rs2_used && (id_rs2 != '0) &&
                (id_is_store ? (cnt_rs2 > LAT_W_L'(1)) : (cnt_rs2 != '0));
  assign waw  = id_reg_wr && (id_rd != '0) && (cnt_rd > lat_e);

  assign stall       = id_valid && !flush && !kill_all && (raw1 || raw2 || waw);
  assign flush_id_ex = stall;
  assign issue       = id_valid && !stall && !flush && !kill_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
